// File: rtl/button_command_scheduler_pkg.sv
// Shared types and helpers for the button command scheduler.
package button_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_HOLDOFF = 2'd3
  } t_btnsched_state;

  typedef logic [1:0] t_cmd_code;

  // Clock cycles in `ms` milliseconds at `fclk` Hz (integer arithmetic).
  function automatic int unsigned ms_to_cycles(input int unsigned fclk, input int unsigned ms);
    return fclk / 1000 * ms;
  endfunction

endpackage

// File: rtl/button_command_scheduler_if.sv
// Button bank / tester command port bundle. master = scheduler side.
interface button_command_scheduler_if;
  import button_sched_pkg::*;

  logic [3:0] i_btns_deb;
  logic       i_cmd_ready;
  logic       i_op_done;
  logic       o_cmd_valid;
  t_cmd_code  o_cmd_code;
  logic       o_busy;
  logic       o_pending;
  logic       o_dropped;
  logic       o_timeout;

  modport master (
    input  i_btns_deb, i_cmd_ready, i_op_done,
    output o_cmd_valid, o_cmd_code, o_busy, o_pending, o_dropped, o_timeout
  );

  modport slave (
    output i_btns_deb, i_cmd_ready, i_op_done,
    input  o_cmd_valid, o_cmd_code, o_busy, o_pending, o_dropped, o_timeout
  );
endinterface

// File: rtl/button_command_scheduler_pending.sv
// One-entry pending command store. A push into a full slot is discarded
// and flagged, unless the slot is popped in the same cycle.
module pending_cmd_slot
  import button_sched_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_push,
  input  t_cmd_code i_push_code,
  input  logic      i_pop,
  output logic      o_occupied,
  output t_cmd_code o_code,
  output logic      o_dropped
);

  logic      occ_q, occ_d;
  t_cmd_code code_q, code_d;
  logic      drop_q, drop_d;

  // Next slot contents: pop first, then accept a push if room was made.
  always_comb begin
    occ_d  = occ_q;
    code_d = code_q;
    drop_d = 1'b0;
    if (i_pop) occ_d = 1'b0;
    if (i_push) begin
      if (!occ_q || i_pop) begin
        occ_d  = 1'b1;
        code_d = i_push_code;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  // Slot registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      occ_q  <= 1'b0;
      code_q <= '0;
      drop_q <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      code_q <= code_d;
      drop_q <= drop_d;
    end
  end

  assign o_occupied = occ_q;
  assign o_code     = code_q;
  assign o_dropped  = drop_q;

endmodule

// File: rtl/button_command_scheduler.sv
// Turns debounced button rises into tester commands: valid/ready issue,
// completion wait with watchdog, then a holdoff before the next issue.
// Optional feature macro: SF_TESTER_AUTO_REPEAT_EN (held button re-issues
// when the holdoff expires).
module button_command_scheduler
  import button_sched_pkg::*;
#(
  parameter int unsigned FCLK       = 20000000,
  parameter int unsigned HOLDOFF_MS = 1,
  parameter int unsigned TIMEOUT_MS = 500
) (
  input logic                        i_clk_mhz,
  input logic                        i_rst_mhz_n,
  button_command_scheduler_if.master bus
);

  localparam int unsigned c_holdoff = ms_to_cycles(FCLK, HOLDOFF_MS);
  localparam int unsigned c_timeout = ms_to_cycles(FCLK, TIMEOUT_MS);
  localparam int unsigned TW        = $clog2(c_timeout);

  // Both terminals must be reachable by the shared timer.
  if (c_holdoff < 2 || c_timeout < 2 || c_holdoff > c_timeout) begin : g_bad_cfg
    $error("button_command_scheduler: holdoff/timeout cycle counts out of range");
  end

  localparam logic [TW-1:0] TO_LAST = TW'(c_timeout - 1);
  localparam logic [TW-1:0] HO_LAST = TW'(c_holdoff - 1);

  t_btnsched_state state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      btns_prev_q, btns_prev_d;
  logic            cmd_valid_q, cmd_valid_d;
  t_cmd_code       cmd_code_q, cmd_code_d;
  logic            busy_q, busy_d;
  logic            timeout_q, timeout_d;

  logic [3:0] rise;
  logic       rise_any;
  t_cmd_code  rise_code;
  logic       push, pop;
  t_cmd_code  push_code;
  logic       slot_occ, slot_drop;
  t_cmd_code  slot_code;

  // Rising-edge detect; lowest index wins when several rise together.
  always_comb begin
    btns_prev_d = bus.i_btns_deb;
    rise        = bus.i_btns_deb & ~btns_prev_q;
    rise_any    = |rise;
    rise_code   = '0;
    for (int i = 3; i >= 0; i--) if (rise[i]) rise_code = t_cmd_code'(i);
  end

  // Next state, slot control, and registered-output values.
  always_comb begin
    state_d    = state_q;
    cmd_code_d = cmd_code_q;
    timeout_d  = 1'b0;
    push       = 1'b0;
    push_code  = rise_code;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (slot_occ) begin
          // Pending command goes first; a same-cycle rise refills the slot.
          state_d    = ST_ISSUE;
          cmd_code_d = slot_code;
          pop        = 1'b1;
          push       = rise_any;
        end else if (rise_any) begin
          state_d    = ST_ISSUE;
          cmd_code_d = rise_code;
        end
      end
      ST_ISSUE: begin
        push = rise_any;
        if (bus.i_cmd_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        push = rise_any;
        if (bus.i_op_done) begin
          state_d = ST_HOLDOFF;
        end else if (timer_q == TO_LAST) begin
          state_d   = ST_HOLDOFF;
          timeout_d = 1'b1;
        end
      end
      ST_HOLDOFF: begin
        push = rise_any;
        if (timer_q == HO_LAST) begin
          state_d = ST_IDLE;
`ifdef SF_TESTER_AUTO_REPEAT_EN
          // Still holding the last button: queue it as a fresh press.
          if (!rise_any && !slot_occ && bus.i_btns_deb[cmd_code_q]) begin
            push      = 1'b1;
            push_code = cmd_code_q;
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Timer restarts on every state change and saturates at its terminal.
    if (state_d != state_q)    timer_d = '0;
    else if (timer_q == TO_LAST) timer_d = timer_q;
    else                       timer_d = timer_q + 1'b1;

    cmd_valid_d = (state_d == ST_ISSUE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State, timer and output registers.
  always_ff @(posedge i_clk_mhz or negedge i_rst_mhz_n) begin
    if (!i_rst_mhz_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      btns_prev_q <= '0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= '0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      btns_prev_q <= btns_prev_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
    end
  end

  pending_cmd_slot u_slot (
    .i_clk       (i_clk_mhz),
    .i_rst_n     (i_rst_mhz_n),
    .i_push      (push),
    .i_push_code (push_code),
    .i_pop       (pop),
    .o_occupied  (slot_occ),
    .o_code      (slot_code),
    .o_dropped   (slot_drop)
  );

  assign bus.o_cmd_valid = cmd_valid_q;
  assign bus.o_cmd_code  = cmd_code_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_pending   = slot_occ;
  assign bus.o_dropped   = slot_drop;
  assign bus.o_timeout   = timeout_q;

endmodule

// File: tb/tb_button_command_scheduler.sv
// Directed + randomized bench for button_command_scheduler.
module tb_button_command_scheduler;
  import button_sched_pkg::*;

  localparam int unsigned FCLK       = 20000;
  localparam int unsigned HOLDOFF_MS = 1;
  localparam int unsigned TIMEOUT_MS = 5;
  localparam int CH = FCLK / 1000 * HOLDOFF_MS;  // 20
  localparam int CT = FCLK / 1000 * TIMEOUT_MS;  // 100

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  button_command_scheduler_if bus();

  button_command_scheduler #(
    .FCLK(FCLK), .HOLDOFF_MS(HOLDOFF_MS), .TIMEOUT_MS(TIMEOUT_MS)
  ) dut (
    .i_clk_mhz   (clk),
    .i_rst_mhz_n (rst_n),
    .bus         (bus)
  );

  int errs = 0;
  int checks = 0;
  t_cmd_code exp_q[$];
  t_cmd_code obs_q[$];
  int n_drop = 0, n_to = 0, hold_viol = 0;
  int exp_drops = 0;

  // Bus monitor: record accepted codes, pulses, and valid-hold violations.
  logic pv = 1'b0, pr = 1'b0;
  t_cmd_code pc = '0;
  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.o_cmd_valid && bus.i_cmd_ready) obs_q.push_back(bus.o_cmd_code);
      if (bus.o_dropped) n_drop <= n_drop + 1;
      if (bus.o_timeout) n_to <= n_to + 1;
      if (pv && !pr && (bus.o_cmd_valid !== 1'b1 || bus.o_cmd_code !== pc))
        hold_viol <= hold_viol + 1;
      pv <= bus.o_cmd_valid;
      pr <= bus.i_cmd_ready;
      pc <= bus.o_cmd_code;
    end else begin
      pv <= 1'b0;
      pr <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tick until condition holds (0: valid, 1: not busy, 2: timeout); n=-1 if bound expires.
  task automatic wait_sig(input int sel, input int lim, output int n);
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < lim) begin
      tick();
      n++;
      case (sel)
        0: hit = (bus.o_cmd_valid === 1'b1);
        1: hit = (bus.o_busy === 1'b0);
        default: hit = (bus.o_timeout === 1'b1);
      endcase
    end
    if (!hit) n = -1;
  endtask

  task automatic pulse_done();
    bus.i_op_done = 1'b1;
    tick();
    bus.i_op_done = 1'b0;
  endtask

  initial begin
    int n, t, vc, issues, b, b2, rd, dd, two, drp;
    logic stable;
    bus.i_btns_deb  = '0;
    bus.i_cmd_ready = 1'b0;
    bus.i_op_done   = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_valid", bus.o_cmd_valid, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_pending", bus.o_pending, 0);
    chk("rst_dropped", bus.o_dropped, 0);
    chk("rst_timeout", bus.o_timeout, 0);
    chk("rst_code", bus.o_cmd_code, 0);
    rst_n = 1'b1;
    tick();

    // A: btn2, ready high, done 10 cycles later
    bus.i_cmd_ready = 1'b1;
    bus.i_btns_deb = 4'b0100;
    tick();
    chk("A_valid", bus.o_cmd_valid, 1);
    chk("A_code", bus.o_cmd_code, 2);
    exp_q.push_back(2'd2);
    tick();
    chk("A_valid_fall", bus.o_cmd_valid, 0);
    chk("A_busy", bus.o_busy, 1);
    bus.i_btns_deb = '0;
    repeat (9) tick();
    pulse_done();
    wait_sig(1, 200, n);
    chk("A_busy_low", n, CH);

    // B: btn0 with ready low for 7 cycles
    bus.i_cmd_ready = 1'b0;
    bus.i_btns_deb = 4'b0001;
    tick();
    exp_q.push_back(2'd0);
    chk("B_code", bus.o_cmd_code, 0);
    vc = (bus.o_cmd_valid === 1'b1) ? 1 : 0;
    stable = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (bus.o_cmd_valid === 1'b1) vc++;
      if (bus.o_cmd_code !== 2'd0) stable = 1'b0;
    end
    bus.i_cmd_ready = 1'b1;
    tick();
    chk("B_valid_cycles", vc, 8);
    chk("B_code_stable", stable, 1);
    chk("B_valid_fall", bus.o_cmd_valid, 0);
    bus.i_btns_deb = '0;
    pulse_done();
    wait_sig(1, 200, n);
    chk("B_busy_low", n, CH);

    // C: btn1, then btn3 and btn0 during WAIT
    bus.i_btns_deb = 4'b0010;
    tick();
    exp_q.push_back(2'd1);
    tick();
    bus.i_btns_deb = '0;
    tick();
    bus.i_btns_deb = 4'b1000;
    tick();
    chk("C_pending", bus.o_pending, 1);
    bus.i_btns_deb = '0;
    tick();
    bus.i_btns_deb = 4'b0001;
    tick();
    exp_drops++;
    chk("C_dropped", bus.o_dropped, 1);
    chk("C_pending_kept", bus.o_pending, 1);
    tick();
    chk("C_dropped_pulse", bus.o_dropped, 0);
    bus.i_btns_deb = '0;
    pulse_done();
    wait_sig(0, 200, n);
    chk("C_reissue_gap", n, CH + 1);
    chk("C_code", bus.o_cmd_code, 3);
    chk("C_pending_clr", bus.o_pending, 0);
    exp_q.push_back(2'd3);
    tick();
    pulse_done();
    wait_sig(1, 200, n);
    chk("C_busy_low", n, CH);

    // D: no done -> watchdog, then pending issue
    bus.i_btns_deb = 4'b0100;
    tick();
    exp_q.push_back(2'd2);
    tick();
    t = 0;
    bus.i_btns_deb = '0;
    tick(); t++;
    bus.i_btns_deb = 4'b1000;
    tick(); t++;
    bus.i_btns_deb = '0;
    wait_sig(2, 300, n);
    chk("D_timeout_at", (n < 0) ? n : t + n, CT);
    wait_sig(0, 200, n);
    chk("D_reissue_gap", n, CH + 1);
    chk("D_code", bus.o_cmd_code, 3);
    exp_q.push_back(2'd3);
    tick();
    pulse_done();
    wait_sig(1, 200, n);
    chk("D_busy_low", n, CH);

    // E: reset while waiting with slot full
    bus.i_btns_deb = 4'b0010;
    tick();
    exp_q.push_back(2'd1);
    tick();
    bus.i_btns_deb = '0;
    tick();
    bus.i_btns_deb = 4'b0100;
    tick();
    chk("E_pending", bus.o_pending, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("E_rst_valid", bus.o_cmd_valid, 0);
    chk("E_rst_busy", bus.o_busy, 0);
    chk("E_rst_pending", bus.o_pending, 0);
    chk("E_rst_code", bus.o_cmd_code, 0);
    chk("E_rst_dropped", bus.o_dropped, 0);
    bus.i_btns_deb = '0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (40) tick();
    chk("E_idle_busy", bus.o_busy, 0);
    chk("E_no_accept", obs_q.size(), exp_q.size());
    bus.i_btns_deb = 4'b1000;
    tick();
    chk("E_new_valid", bus.o_cmd_valid, 1);
    chk("E_new_code", bus.o_cmd_code, 3);
    exp_q.push_back(2'd3);
    tick();
    bus.i_btns_deb = '0;
    pulse_done();
    wait_sig(1, 200, n);
    chk("E_busy_low", n, CH);

    // F: hold btn1 across holdoffs
    issues = 0;
    bus.i_btns_deb = 4'b0010;
    for (int r = 0; r < 3; r++) begin
      wait_sig(0, CH + 30, n);
      if (n >= 0) begin
        issues++;
        chk("F_code", bus.o_cmd_code, 1);
        exp_q.push_back(2'd1);
        tick();
        if (r == 2) bus.i_btns_deb = '0;
        repeat (3) tick();
        pulse_done();
      end
    end
    bus.i_btns_deb = '0;
    wait_sig(1, 200, n);
`ifdef SF_TESTER_AUTO_REPEAT_EN
    chk("F_issues", issues, 3);
`else
    chk("F_issues", issues, 1);
`endif

    // R: randomized single/double commands against spec timing
    for (int it = 0; it < 20; it++) begin
      b   = $urandom_range(3);
      b2  = $urandom_range(3);
      rd  = $urandom_range(5);
      dd  = $urandom_range(20, 1);
      two = $urandom_range(1);
      drp = $urandom_range(1);
      bus.i_cmd_ready = (rd == 0);
      bus.i_btns_deb = 4'(1 << b);
      tick();
      chk("R_valid", bus.o_cmd_valid, 1);
      chk("R_code", bus.o_cmd_code, b);
      exp_q.push_back(t_cmd_code'(b));
      vc = 1;
      for (int k = 0; k < rd; k++) begin
        tick();
        if (bus.o_cmd_valid === 1'b1) vc++;
      end
      bus.i_cmd_ready = 1'b1;
      tick();
      chk("R_valid_cycles", vc, rd + 1);
      bus.i_btns_deb = '0;
      tick();
      if (two != 0) begin
        bus.i_btns_deb = 4'(1 << b2);
        tick();
        bus.i_btns_deb = '0;
        tick();
        if (drp != 0) begin
          bus.i_btns_deb = 4'(1 << ((b2 + 1) % 4));
          tick();
          bus.i_btns_deb = '0;
          tick();
          exp_drops++;
        end
      end
      repeat (dd) tick();
      pulse_done();
      if (two != 0) begin
        wait_sig(0, 200, n);
        chk("R_reissue_gap", n, CH + 1);
        chk("R_code2", bus.o_cmd_code, b2);
        exp_q.push_back(t_cmd_code'(b2));
        tick();
        repeat (3) tick();
        pulse_done();
      end
      wait_sig(1, 200, n);
      chk("R_busy_low", n, CH);
    end

    // Scoreboard and pulse totals
    tick();
    chk("SB_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk("SB_code", obs_q[i], exp_q[i]);
    chk("drops_total", n_drop, exp_drops);
    chk("timeouts_total", n_to, 1);
    chk("valid_hold", hold_viol, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
